// File: rtl/pipelined_control_unit.sv
// Main decoder for the 5-stage RV32I pipeline. It decodes in ID and carries the control bundle
// through the ID/EX, EX/MEM and MEM/WB registers. Branches are resolved in EX.
module pipelined_control_unit #(
    parameter bit ENABLE_UPPER        = 1'b1,
    parameter bit ENABLE_ALL_BRANCHES = 1'b1,
    parameter bit ILLEGAL_STICKY      = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] op_d,
    input  logic [2:0] funct3_d,
    input  logic       stall_d,
    input  logic       flush_e,
    input  logic       zero_e,
    input  logic       lt_e,
    input  logic       ltu_e,
    output logic [2:0] immsrc_d,
    output logic       illegal_d,
    output logic       alusrca_e,
    output logic       alusrcb_e,
    output logic [1:0] aluop_e,
    output logic [2:0] funct3_e,
    output logic       pcsrc_e,
    output logic       jalr_e,
    output logic       memwrite_m,
    output logic       regwrite_m,
    output logic [1:0] resultsrc_m,
    output logic       regwrite_w,
    output logic [1:0] resultsrc_w,
    output logic       illegal_w,
    output logic       illegal_seen
);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_ALUI   = 7'b0010011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_ALUR   = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef struct packed {
        logic       regwrite;
        logic [1:0] resultsrc;
        logic       memwrite;
        logic       branch;
        logic       jump;
        logic       jalr;
        logic [1:0] aluop;
        logic       alusrca;
        logic       alusrcb;
        logic       illegal;
    } ctrl_t;

    ctrl_t      ctrl_d;
    ctrl_t      ctrl_e;
    logic [2:0] funct3_q;
    logic       branch_ok;
    logic       illegal_m;
    logic       cond_e;

    always_comb begin
        branch_ok = 1'b0;
        case (funct3_d)
            3'b000, 3'b001:                 branch_ok = 1'b1;
            3'b100, 3'b101, 3'b110, 3'b111: branch_ok = ENABLE_ALL_BRANCHES;
            default:                        branch_ok = 1'b0;
        endcase
    end

    // Illegal or disabled encodings leave every control at zero, so they travel down the pipe as bubbles.
    always_comb begin
        ctrl_d   = '0;
        immsrc_d = 3'b000;
        case (op_d)
            OP_LOAD: begin
                ctrl_d.regwrite  = 1'b1;
                ctrl_d.alusrcb   = 1'b1;
                ctrl_d.resultsrc = 2'b01;
            end
            OP_ALUI: begin
                ctrl_d.regwrite = 1'b1;
                ctrl_d.alusrcb  = 1'b1;
                ctrl_d.aluop    = 2'b10;
            end
            OP_JALR: begin
                ctrl_d.regwrite  = 1'b1;
                ctrl_d.alusrcb   = 1'b1;
                ctrl_d.resultsrc = 2'b10;
                ctrl_d.jump      = 1'b1;
                ctrl_d.jalr      = 1'b1;
            end
            OP_STORE: begin
                immsrc_d        = 3'b001;
                ctrl_d.alusrcb  = 1'b1;
                ctrl_d.memwrite = 1'b1;
            end
            OP_ALUR: begin
                ctrl_d.regwrite = 1'b1;
                ctrl_d.aluop    = 2'b10;
            end
            OP_BRANCH: begin
                if (branch_ok) begin
                    immsrc_d      = 3'b010;
                    ctrl_d.branch = 1'b1;
                    ctrl_d.aluop  = 2'b01;
                end else begin
                    ctrl_d.illegal = 1'b1;
                end
            end
            OP_JAL: begin
                immsrc_d         = 3'b011;
                ctrl_d.regwrite  = 1'b1;
                ctrl_d.resultsrc = 2'b10;
                ctrl_d.jump      = 1'b1;
            end
            OP_LUI: begin
                if (ENABLE_UPPER) begin
                    immsrc_d         = 3'b100;
                    ctrl_d.regwrite  = 1'b1;
                    ctrl_d.alusrcb   = 1'b1;
                    ctrl_d.resultsrc = 2'b11;
                end else begin
                    ctrl_d.illegal = 1'b1;
                end
            end
            OP_AUIPC: begin
                if (ENABLE_UPPER) begin
                    immsrc_d        = 3'b100;
                    ctrl_d.regwrite = 1'b1;
                    ctrl_d.alusrca  = 1'b1;
                    ctrl_d.alusrcb  = 1'b1;
                end else begin
                    ctrl_d.illegal = 1'b1;
                end
            end
            default: ctrl_d.illegal = 1'b1;
        endcase
    end

    assign illegal_d = ctrl_d.illegal;

    // A stall and a flush in the same cycle still insert only one bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_e   <= '0;
            funct3_q <= 3'b000;
        end else if (flush_e || stall_d) begin
            ctrl_e   <= '0;
            funct3_q <= 3'b000;
        end else begin
            ctrl_e   <= ctrl_d;
            funct3_q <= funct3_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regwrite_m  <= 1'b0;
            resultsrc_m <= 2'b00;
            memwrite_m  <= 1'b0;
            illegal_m   <= 1'b0;
        end else begin
            regwrite_m  <= ctrl_e.regwrite;
            resultsrc_m <= ctrl_e.resultsrc;
            memwrite_m  <= ctrl_e.memwrite;
            illegal_m   <= ctrl_e.illegal;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regwrite_w  <= 1'b0;
            resultsrc_w <= 2'b00;
            illegal_w   <= 1'b0;
        end else begin
            regwrite_w  <= regwrite_m;
            resultsrc_w <= resultsrc_m;
            illegal_w   <= illegal_m;
        end
    end

    assign alusrca_e = ctrl_e.alusrca;
    assign alusrcb_e = ctrl_e.alusrcb;
    assign aluop_e   = ctrl_e.aluop;
    assign jalr_e    = ctrl_e.jalr;
    assign funct3_e  = funct3_q;

    always_comb begin
        cond_e = 1'b0;
        case (funct3_q)
            3'b000:  cond_e = zero_e;
            3'b001:  cond_e = ~zero_e;
            3'b100:  cond_e = lt_e;
            3'b101:  cond_e = ~lt_e;
            3'b110:  cond_e = ltu_e;
            3'b111:  cond_e = ~ltu_e;
            default: cond_e = 1'b0;
        endcase
        pcsrc_e = ctrl_e.jump | (ctrl_e.branch & cond_e);
    end

    // In sticky mode, the flag rises together with illegal_w and then holds until reset.
    generate
        if (ILLEGAL_STICKY) begin : g_sticky
            logic seen_q;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) seen_q <= 1'b0;
                else if (illegal_w) seen_q <= 1'b1;
            end
            assign illegal_seen = illegal_w | seen_q;
        end else begin : g_mirror
            assign illegal_seen = illegal_w;
        end
    endgenerate

endmodule

// File: tb/tb_pipelined_control_unit.sv
// Bench for pipelined_control_unit. It drives one instance with every option enabled and one with every
// option disabled from the same stimulus, and compares both against a stage-queue reference model.
module tb_pipelined_control_unit;

    typedef struct packed {
        logic       regwrite;
        logic [2:0] immsrc;
        logic       alusrca;
        logic       alusrcb;
        logic       memwrite;
        logic [1:0] resultsrc;
        logic       branch;
        logic       jump;
        logic       jalr;
        logic [1:0] aluop;
        logic [2:0] funct3;
        logic       illegal;
    } ctl_t;

    typedef struct packed {
        logic       alusrca_e;
        logic       alusrcb_e;
        logic [1:0] aluop_e;
        logic [2:0] funct3_e;
        logic       pcsrc_e;
        logic       jalr_e;
        logic       memwrite_m;
        logic       regwrite_m;
        logic [1:0] resultsrc_m;
        logic       regwrite_w;
        logic [1:0] resultsrc_w;
        logic       illegal_w;
        logic       illegal_seen;
        logic [2:0] immsrc_d;
        logic       illegal_d;
    } obs_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] op_d;
    logic [2:0] funct3_d;
    logic       stall_d, flush_e, zero_e, lt_e, ltu_e;

    logic [2:0] f_immsrc_d, m_immsrc_d, f_funct3_e, m_funct3_e;
    logic [1:0] f_aluop_e, m_aluop_e, f_resultsrc_m, m_resultsrc_m, f_resultsrc_w, m_resultsrc_w;
    logic f_illegal_d, f_alusrca_e, f_alusrcb_e, f_pcsrc_e, f_jalr_e, f_memwrite_m, f_regwrite_m;
    logic f_regwrite_w, f_illegal_w, f_illegal_seen;
    logic m_illegal_d, m_alusrca_e, m_alusrcb_e, m_pcsrc_e, m_jalr_e, m_memwrite_m, m_regwrite_m;
    logic m_regwrite_w, m_illegal_w, m_illegal_seen;

    obs_t obs [2];
    ctl_t ex [2];
    ctl_t mem [2];
    ctl_t wb [2];
    bit   seen [2];
    bit   cfg_upper [2]  = '{1'b1, 1'b0};
    bit   cfg_allbr [2]  = '{1'b1, 1'b0};
    bit   cfg_sticky [2] = '{1'b1, 1'b0};
    string cfg_name [2]  = '{"full", "min"};

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    pipelined_control_unit u_full (
        .clk(clk), .rst(rst), .op_d(op_d), .funct3_d(funct3_d), .stall_d(stall_d),
        .flush_e(flush_e), .zero_e(zero_e), .lt_e(lt_e), .ltu_e(ltu_e),
        .immsrc_d(f_immsrc_d), .illegal_d(f_illegal_d), .alusrca_e(f_alusrca_e),
        .alusrcb_e(f_alusrcb_e), .aluop_e(f_aluop_e), .funct3_e(f_funct3_e), .pcsrc_e(f_pcsrc_e),
        .jalr_e(f_jalr_e), .memwrite_m(f_memwrite_m), .regwrite_m(f_regwrite_m),
        .resultsrc_m(f_resultsrc_m), .regwrite_w(f_regwrite_w), .resultsrc_w(f_resultsrc_w),
        .illegal_w(f_illegal_w), .illegal_seen(f_illegal_seen)
    );

    pipelined_control_unit #(
        .ENABLE_UPPER(1'b0), .ENABLE_ALL_BRANCHES(1'b0), .ILLEGAL_STICKY(1'b0)
    ) u_min (
        .clk(clk), .rst(rst), .op_d(op_d), .funct3_d(funct3_d), .stall_d(stall_d),
        .flush_e(flush_e), .zero_e(zero_e), .lt_e(lt_e), .ltu_e(ltu_e),
        .immsrc_d(m_immsrc_d), .illegal_d(m_illegal_d), .alusrca_e(m_alusrca_e),
        .alusrcb_e(m_alusrcb_e), .aluop_e(m_aluop_e), .funct3_e(m_funct3_e), .pcsrc_e(m_pcsrc_e),
        .jalr_e(m_jalr_e), .memwrite_m(m_memwrite_m), .regwrite_m(m_regwrite_m),
        .resultsrc_m(m_resultsrc_m), .regwrite_w(m_regwrite_w), .resultsrc_w(m_resultsrc_w),
        .illegal_w(m_illegal_w), .illegal_seen(m_illegal_seen)
    );

    assign obs[0] = {f_alusrca_e, f_alusrcb_e, f_aluop_e, f_funct3_e, f_pcsrc_e, f_jalr_e,
                     f_memwrite_m, f_regwrite_m, f_resultsrc_m, f_regwrite_w, f_resultsrc_w,
                     f_illegal_w, f_illegal_seen, f_immsrc_d, f_illegal_d};
    assign obs[1] = {m_alusrca_e, m_alusrcb_e, m_aluop_e, m_funct3_e, m_pcsrc_e, m_jalr_e,
                     m_memwrite_m, m_regwrite_m, m_resultsrc_m, m_regwrite_w, m_resultsrc_w,
                     m_illegal_w, m_illegal_seen, m_immsrc_d, m_illegal_d};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Control words follow the instruction table column order:
    // regwrite/immsrc/alusrca/alusrcb/memwrite/resultsrc/branch/jump/jalr/aluop.
    function automatic ctl_t ref_decode(input logic [6:0] op, input logic [2:0] f3,
                                        input bit upper, input bit allbr);
        ctl_t       c;
        logic [13:0] w;
        bit         legal;
        legal = 1'b1;
        w     = '0;
        case (op)
            7'b0000011: w = 14'b1_000_0_1_0_01_0_0_0_00;
            7'b0010011: w = 14'b1_000_0_1_0_00_0_0_0_10;
            7'b1100111: w = 14'b1_000_0_1_0_10_0_1_1_00;
            7'b0100011: w = 14'b0_001_0_1_1_00_0_0_0_00;
            7'b0110011: w = 14'b1_000_0_0_0_00_0_0_0_10;
            7'b1100011: begin
                w = 14'b0_010_0_0_0_00_1_0_0_01;
                legal = (f3 == 3'd0) || (f3 == 3'd1) || (allbr && f3 >= 3'd4);
            end
            7'b1101111: w = 14'b1_011_0_0_0_10_0_1_0_00;
            7'b0110111: begin w = 14'b1_100_0_1_0_11_0_0_0_00; legal = upper; end
            7'b0010111: begin w = 14'b1_100_1_1_0_00_0_0_0_00; legal = upper; end
            default:    legal = 1'b0;
        endcase
        if (!legal) w = '0;
        c = '0;
        {c.regwrite, c.immsrc, c.alusrca, c.alusrcb, c.memwrite, c.resultsrc,
         c.branch, c.jump, c.jalr, c.aluop} = w;
        c.funct3  = f3;
        c.illegal = !legal;
        return c;
    endfunction

    function automatic logic ref_pcsrc(input ctl_t e, input logic z, input logic l, input logic lu);
        logic take;
        case (e.funct3)
            3'd0: take = z;
            3'd1: take = !z;
            3'd4: take = l;
            3'd5: take = !l;
            3'd6: take = lu;
            3'd7: take = !lu;
            default: take = 1'b0;
        endcase
        return e.jump || (e.branch && take);
    endfunction

    task automatic check_comb(input int c);
        ctl_t d;
        d = ref_decode(op_d, funct3_d, cfg_upper[c], cfg_allbr[c]);
        check({cfg_name[c], ".immsrc_d"}, 32'(obs[c].immsrc_d), 32'(d.immsrc));
        check({cfg_name[c], ".illegal_d"}, 32'(obs[c].illegal_d), 32'(d.illegal));
        check({cfg_name[c], ".pcsrc_e"}, 32'(obs[c].pcsrc_e), 32'(ref_pcsrc(ex[c], zero_e, lt_e, ltu_e)));
    endtask

    task automatic check_regs(input int c);
        string n;
        n = cfg_name[c];
        check({n, ".alusrca_e"}, 32'(obs[c].alusrca_e), 32'(ex[c].alusrca));
        check({n, ".alusrcb_e"}, 32'(obs[c].alusrcb_e), 32'(ex[c].alusrcb));
        check({n, ".aluop_e"}, 32'(obs[c].aluop_e), 32'(ex[c].aluop));
        check({n, ".funct3_e"}, 32'(obs[c].funct3_e), 32'(ex[c].funct3));
        check({n, ".jalr_e"}, 32'(obs[c].jalr_e), 32'(ex[c].jalr));
        check({n, ".pcsrc_e"}, 32'(obs[c].pcsrc_e), 32'(ref_pcsrc(ex[c], zero_e, lt_e, ltu_e)));
        check({n, ".memwrite_m"}, 32'(obs[c].memwrite_m), 32'(mem[c].memwrite));
        check({n, ".regwrite_m"}, 32'(obs[c].regwrite_m), 32'(mem[c].regwrite));
        check({n, ".resultsrc_m"}, 32'(obs[c].resultsrc_m), 32'(mem[c].resultsrc));
        check({n, ".regwrite_w"}, 32'(obs[c].regwrite_w), 32'(wb[c].regwrite));
        check({n, ".resultsrc_w"}, 32'(obs[c].resultsrc_w), 32'(wb[c].resultsrc));
        check({n, ".illegal_w"}, 32'(obs[c].illegal_w), 32'(wb[c].illegal));
        check({n, ".illegal_seen"}, 32'(obs[c].illegal_seen), 32'(seen[c]));
    endtask

    task automatic model_clear();
        for (int c = 0; c < 2; c++) begin
            ex[c] = '0; mem[c] = '0; wb[c] = '0; seen[c] = 1'b0;
        end
    endtask

    // One full clock. Inputs are applied, the ID outputs are checked, and after the edge the staged outputs are checked.
    task automatic cycle(input logic [6:0] op, input logic [2:0] f3, input logic st, input logic fl,
                         input logic z, input logic l, input logic lu);
        op_d = op; funct3_d = f3; stall_d = st; flush_e = fl; zero_e = z; lt_e = l; ltu_e = lu;
        #1;
        for (int c = 0; c < 2; c++) check_comb(c);
        @(posedge clk);
        for (int c = 0; c < 2; c++) begin
            wb[c]  = mem[c];
            mem[c] = ex[c];
            ex[c]  = (st || fl) ? '0 : ref_decode(op, f3, cfg_upper[c], cfg_allbr[c]);
            seen[c] = cfg_sticky[c] ? (seen[c] || wb[c].illegal) : wb[c].illegal;
        end
        #1;
        for (int c = 0; c < 2; c++) check_regs(c);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        model_clear();
        for (int c = 0; c < 2; c++) check_regs(c);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        for (int c = 0; c < 2; c++) check_regs(c);
    endtask

    localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011, BR = 7'b1100011;
    localparam logic [6:0] LUI = 7'b0110111, AUIPC = 7'b0010111, ILL = 7'b1111111;

    initial begin
        logic [6:0] ops [12];
        ops = '{LW, 7'b0010011, 7'b1100111, SW, RT, BR, BR, 7'b1101111, LUI, AUIPC, ILL, BR};
        rst = 1'b1; op_d = '0; funct3_d = '0; stall_d = 0; flush_e = 0; zero_e = 0; lt_e = 0; ltu_e = 0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        for (int c = 0; c < 2; c++) check_regs(c);
        rst = 1'b0;

        cycle(LW, 3'b010, 0, 0, 0, 0, 0);
        check("lw.alusrcb_e", 32'(obs[0].alusrcb_e), 32'd1);
        check("lw.aluop_e", 32'(obs[0].aluop_e), 32'd0);
        cycle(RT, 3'b000, 0, 0, 0, 0, 0);
        check("lw.resultsrc_m", 32'(obs[0].resultsrc_m), 32'd1);
        check("lw.memwrite_m", 32'(obs[0].memwrite_m), 32'd0);
        cycle(SW, 3'b010, 0, 0, 0, 0, 0);
        check("lw.regwrite_w", 32'(obs[0].regwrite_w), 32'd1);
        check("lw.resultsrc_w", 32'(obs[0].resultsrc_w), 32'd1);
        do_reset();

        op_d = BR; funct3_d = 3'b100;
        #1;
        check("blt.full.illegal_d", 32'(obs[0].illegal_d), 32'd0);
        check("blt.min.illegal_d", 32'(obs[1].illegal_d), 32'd1);
        cycle(BR, 3'b100, 0, 0, 0, 0, 0);
        lt_e = 1'b1; #1;
        check("blt.lt1.pcsrc_e", 32'(obs[0].pcsrc_e), 32'd1);
        check("blt.min.pcsrc_e", 32'(obs[1].pcsrc_e), 32'd0);
        lt_e = 1'b0; #1;
        check("blt.lt0.pcsrc_e", 32'(obs[0].pcsrc_e), 32'd0);
        cycle(BR, 3'b111, 0, 0, 0, 0, 0);
        ltu_e = 1'b0; #1;
        check("bgeu.ltu0.pcsrc_e", 32'(obs[0].pcsrc_e), 32'd1);

        cycle(SW, 3'b010, 1, 0, 0, 0, 0);
        check("sw.stall.alusrcb_e", 32'(obs[0].alusrcb_e), 32'd0);
        cycle(RT, 3'b000, 1, 1, 0, 0, 0);
        check("sw.stall.memwrite_m", 32'(obs[0].memwrite_m), 32'd0);
        cycle(SW, 3'b010, 0, 0, 0, 0, 0);
        check("after_bubble.sw.alusrcb_e", 32'(obs[0].alusrcb_e), 32'd1);

        op_d = LUI; funct3_d = 3'b000;
        #1;
        check("lui.immsrc_d", 32'(obs[0].immsrc_d), 32'd4);
        check("lui.min.illegal_d", 32'(obs[1].illegal_d), 32'd1);
        cycle(LUI, 3'b000, 0, 0, 0, 0, 0);
        cycle(AUIPC, 3'b000, 0, 0, 0, 0, 0);
        check("auipc.alusrca_e", 32'(obs[0].alusrca_e), 32'd1);
        cycle(ILL, 3'b000, 0, 0, 0, 0, 0);
        check("lui.resultsrc_w", 32'(obs[0].resultsrc_w), 32'd3);
        cycle(RT, 3'b000, 0, 0, 0, 0, 0);
        cycle(RT, 3'b000, 0, 0, 0, 0, 0);
        check("ill.full.illegal_w", 32'(obs[0].illegal_w), 32'd1);
        check("ill.min.illegal_w", 32'(obs[1].illegal_w), 32'd1);
        cycle(RT, 3'b000, 0, 0, 0, 0, 0);
        check("ill.full.seen_holds", 32'(obs[0].illegal_seen), 32'd1);
        check("ill.min.seen_drops", 32'(obs[1].illegal_seen), 32'd0);

        for (int i = 0; i < 3000; i++) begin
            logic [6:0] op;
            op = ($urandom_range(0, 7) == 0) ? 7'($urandom) : ops[$urandom_range(0, 11)];
            cycle(op, 3'($urandom), ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
                  1'($urandom), 1'($urandom), 1'($urandom));
            if ($urandom_range(0, 99) == 0) do_reset();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
